// File: rtl/gate_vec_seq_if.sv
// Bundle of the sequencer's control and gate-test signals.
//
// Purpose: carry the run request, the two gate stimulus bits, the gate
// result and the run status between the sequencer and whatever drives
// or observes it.
//
// Signals:
//   start    request to run the four-vector sequence (one-cycle pulse)
//   a_out    stimulus to the downstream gate's a input
//   b_out    stimulus to the downstream gate's b input
//   f_in     downstream gate's combinational result
//   busy     a sequence is in progress
//   done     one-cycle pulse at the end of a sequence
//   vec_idx  index of the vector currently driven
//   err_cnt  mismatching vectors in the current or last run
//   pass     last completed run had no mismatches
//
// Modports:
//   slave   the sequencer itself
//   master  the environment around it (requester plus gate under test)
interface gate_vec_seq_if;
  logic       start;
  logic       f_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic [1:0] vec_idx;
  logic [2:0] err_cnt;
  logic       pass;

  modport slave (
    input  start, f_in,
    output a_out, b_out, busy, done, vec_idx, err_cnt, pass
  );

  modport master (
    output start, f_in,
    input  a_out, b_out, busy, done, vec_idx, err_cnt, pass
  );
endinterface

// File: rtl/gate_vec_seq.sv
// Two-input gate exerciser.
//
// Purpose: on a start request, drive the four input combinations
// {a,b} = 00, 01, 11, 10 onto a downstream two-input gate, holding each
// for HOLD cycles (Gray order, so only one input toggles per step). On
// the last hold cycle of each vector the gate result is compared with
// the expected function selected by OP, and mismatches are counted. A
// one-cycle done pulse ends the run; pass reports a clean run.
//
// Parameters:
//   HOLD  cycles each vector is held (2..255)
//   OP    expected gate function: 0 AND, 1 OR, 2 XOR, 3 XNOR
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    gate_vec_seq_if.slave (start, f_in in; a_out, b_out, busy,
//          done, vec_idx, err_cnt, pass out)
//
// Build option:
//   GATE_VEC_SEQ_CHECK_EN  when defined, the result checker is compiled in.
//                          When undefined, f_in is ignored, err_cnt stays 0
//                          and pass pulses high together with done.
//
// Run latency from the cycle start is presented to the done cycle is
// 4*HOLD+1 cycles.
module gate_vec_seq #(
  parameter int unsigned HOLD = 10,
  parameter logic [1:0]  OP   = 2'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  gate_vec_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FINISH
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

`ifdef GATE_VEC_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [7:0] hold_q;
  logic [1:0] vec_q;
  logic       a_q, b_q;
  logic [2:0] err_q, err_d;
  logic       pass_q;
  logic       last_hold;
  logic       last_vec;

  // Expected output of the gate under test.
  function automatic logic gate_fn(input logic a, input logic b);
    case (OP)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Gray-ordered vector table: idx 0..3 -> {a,b} = 00, 01, 11, 10.
  function automatic logic vec_a(input logic [1:0] idx);
    return idx[1];
  endfunction

  function automatic logic vec_b(input logic [1:0] idx);
    return idx[1] ^ idx[0];
  endfunction

  assign last_hold = (hold_q == HOLD_LAST);
  assign last_vec  = (vec_q == 2'd3);

  // NOTE: every signal written in always_comb gets a default on entry, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DRIVE;
      DRIVE:   if (last_hold && last_vec) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef GATE_VEC_SEQ_CHECK_EN
  logic mismatch;

  // Sample the gate once per vector, on the final hold cycle, when its
  // output has had the longest time to settle. The count saturates at 4,
  // which is also the most a four-vector run can reach.
  assign mismatch = (state_q == DRIVE) && last_hold &&
                    (bus.f_in != gate_fn(a_q, b_q));
  assign err_d    = (mismatch && (err_q != 3'd4)) ? err_q + 3'd1 : err_q;
`else
  logic unused_check;

  assign err_d        = 3'd0;
  assign unused_check = bus.f_in ^ gate_fn(a_q, b_q);
`endif

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 8'd0;
      vec_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // A new run starts clean; the previous result is held until now.
          if (state_d == DRIVE) begin
            hold_q <= 8'd0;
            vec_q  <= 2'd0;
            a_q    <= vec_a(2'd0);
            b_q    <= vec_b(2'd0);
            err_q  <= 3'd0;
            pass_q <= 1'b0;
          end
        end
        DRIVE: begin
          err_q <= err_d;
          if (last_hold) begin
            hold_q <= 8'd0;
            if (last_vec) begin
              // Leaving for FINISH: park the gate inputs and publish the
              // verdict, which already includes the final sample.
              vec_q  <= 2'd0;
              a_q    <= 1'b0;
              b_q    <= 1'b0;
              pass_q <= CHECK_EN ? (err_d == 3'd0) : 1'b1;
            end else begin
              vec_q <= vec_q + 2'd1;
              a_q   <= vec_a(vec_q + 2'd1);
              b_q   <= vec_b(vec_q + 2'd1);
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        FINISH: begin
          // Without the checker pass is only a companion pulse to done.
          if (!CHECK_EN) pass_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.a_out   = a_q;
  assign bus.b_out   = b_q;
  assign bus.vec_idx = vec_q;
  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == FINISH);

endmodule

// File: tb/tb_gate_vec_seq.sv
// Self-checking bench for gate_vec_seq.
//
// A behavioural gate (a 4-entry truth table indexed by {a,b}, or a
// free-running random bit) answers the DUT's stimulus. Each run pushes
// its expected outcome, computed from the vector list and the ideal gate
// function, onto a scoreboard; a monitor process checks the driven
// vectors every cycle and pops/compares the outcome on every done pulse.
module tb_gate_vec_seq;

  localparam int unsigned HOLD = 4;
  localparam logic [1:0]  OP   = 2'd3;

  typedef struct {
    int         start_cyc;
    int         done_cyc;
    logic [2:0] err;
    logic       pass;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_seen = 0;

  logic [3:0] tt;
  bit         toggle;
  exp_t       sb_q[$];
  logic [1:0] order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  gate_vec_seq_if bus ();

  gate_vec_seq #(.HOLD(HOLD), .OP(OP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ideal(input logic a, input logic b);
    case (OP)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return !(a ^ b);
    endcase
  endfunction

  function automatic logic [3:0] ideal_table();
    logic [3:0] t;
    for (int i = 0; i < 4; i++) t[i] = ideal(i[1], i[0]);
    return t;
  endfunction

  // Number of vectors on which a gate with truth table t disagrees with OP.
  function automatic logic [2:0] model_err(input logic [3:0] t);
    int n = 0;
    for (int v = 0; v < 4; v++)
      if (t[order[v]] != ideal(order[v][1], order[v][0])) n++;
    return 3'(n);
  endfunction

  // Downstream gate model, updated mid-cycle from the registered a/b.
  initial begin
    bus.f_in = 1'b0;
    forever begin
      @(negedge clk);
      bus.f_in = toggle ? 1'($urandom_range(0, 1)) : tt[{bus.a_out, bus.b_out}];
    end
  end

  // Monitor: per-cycle vector check and scoreboard compare on done.
  initial begin : monitor
    exp_t e;
    int   k;
    int   v;
    logic [3:0] exp_vec;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            check("spurious_done", bus.done, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("done_err_cnt", bus.err_cnt, e.err);
            check("done_pass", bus.pass, e.pass);
            check("done_busy", bus.busy, 1'b1);
            done_seen++;
          end
        end else if (bus.busy) begin
          if (sb_q.size() == 0) begin
            check("busy_without_run", bus.busy, 1'b0);
          end else begin
            k = cyc - sb_q[0].start_cyc - 1;
            v = k / int'(HOLD);
            if (v > 3) v = 3;
            exp_vec = {order[v], v[1:0]};
            check("drive_vec", {bus.a_out, bus.b_out, bus.vec_idx}, exp_vec);
          end
        end else begin
          check("idle_vec", {bus.a_out, bus.b_out, bus.vec_idx}, 4'h0);
        end
      end
    end
  end

  task automatic run(input logic [3:0] table_in, input bit toggle_in,
                     input bit restart_mid);
    exp_t e;
    int   seen;
    @(negedge clk);
    tt     = table_in;
    toggle = toggle_in;
    e.start_cyc = cyc;
    e.done_cyc  = cyc + 4 * int'(HOLD) + 1;
`ifdef GATE_VEC_SEQ_CHECK_EN
    e.err  = model_err(table_in);
    e.pass = (e.err == 3'd0);
`else
    e.err  = 3'd0;
    e.pass = 1'b1;
`endif
    sb_q.push_back(e);
    seen = done_seen;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (restart_mid) begin
      // Land inside vector 2 and request again; must be ignored.
      repeat (2 * HOLD + 1) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int i = 0; i < 4 * int'(HOLD) + 8 && done_seen == seen; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_count", done_seen, seen + 1);
    repeat (3) @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);
    check("held_err_cnt", bus.err_cnt, e.err);
`ifdef GATE_VEC_SEQ_CHECK_EN
    check("held_pass", bus.pass, e.pass);
`else
    check("held_pass", bus.pass, 1'b0);
`endif
  endtask

  task automatic abort_run();
    exp_t e;
    int   seen;
    @(negedge clk);
    tt     = 4'b0000;
    toggle = 1'b0;
    e.start_cyc = cyc;
    e.done_cyc  = cyc + 4 * int'(HOLD) + 1;
    e.err  = 3'd0;
    e.pass = 1'b0;
    sb_q.push_back(e);
    seen = done_seen;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (HOLD + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {bus.a_out, bus.b_out, bus.busy, bus.done,
                            bus.pass, bus.vec_idx, bus.err_cnt}, 10'h0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * HOLD + 4) @(negedge clk);
    check("no_done_after_abort", done_seen, seen);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    tt        = 4'b0000;
    toggle    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.a_out, bus.b_out, bus.busy, bus.done,
                            bus.pass, bus.vec_idx, bus.err_cnt}, 10'h0);
    rst_n = 1'b1;

    run(ideal_table(), 1'b0, 1'b0);   // correct gate
    run(4'b0000,       1'b0, 1'b0);   // stuck at 0
    run(ideal_table(), 1'b0, 1'b0);   // clean run clears the count
    run(4'b1000,       1'b0, 1'b0);   // AND gate attached
    run(4'b1110,       1'b0, 1'b0);   // OR gate, mismatch on final vector
    run(4'b1111,       1'b0, 1'b0);   // stuck at 1
    run(ideal_table(), 1'b0, 1'b1);   // start pulsed during vector 2
    abort_run();
    run(ideal_table(), 1'b0, 1'b0);   // normal run after reset abort
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end
`ifndef GATE_VEC_SEQ_CHECK_EN
    run(4'b0000, 1'b1, 1'b0);         // f_in toggling randomly
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks",
             n_errors, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/gate_vec_seq.md
GATE_VEC_SEQ -- requirements
Module: gate_vec_seq

Interface
REQ-001 The block SHALL have parameter HOLD, default 10, meaning the cycles each input vector is held (legal 2..255).
REQ-002 The block SHALL have parameter OP, default 2'd0, meaning the expected gate function: 0 AND, 1 OR, 2 XOR, 3 XNOR.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to run the four-vector sequence.
REQ-006 The block SHALL have port a_out, output, 1, which drives the downstream gate's a input.
REQ-007 The block SHALL have port b_out, output, 1, which drives the downstream gate's b input.
REQ-008 The block SHALL have port f_in, input, 1, the downstream gate's combinational result.
REQ-009 The block SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse at the end of a sequence.
REQ-011 The block SHALL have port vec_idx, output, 2, the index of the vector currently driven.
REQ-012 The block SHALL have port err_cnt, output, 3, the number of mismatching vectors in the current or last run.
REQ-013 The block SHALL have port pass, output, 1, high when the last completed run had err_cnt==0.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, FINISH.
- IDLE->DRIVE on start.
- DRIVE->FINISH after the last hold cycle of vector 3.
- FINISH->IDLE unconditionally, after one cycle.
REQ-015 The vector order SHALL be {a,b} = 00, 01, 11, 10 for vec_idx 0..3, so only one input toggles per step.
REQ-016 a_out and b_out SHALL be registered, and SHALL take vector 0 in the first DRIVE cycle, the cycle after start is sampled.
REQ-017 A hold counter SHALL run 0..HOLD-1 per vector; on count HOLD-1 the block advances vec_idx and resets the count.
REQ-018 f_in SHALL be sampled on hold count HOLD-1 and compared with OP applied to the current a_out and b_out; each mismatch increments err_cnt by 1 (maximum 4, no overflow).
REQ-019 On the IDLE->DRIVE transition, err_cnt SHALL clear to 0 and pass SHALL clear to 0.
REQ-020 busy SHALL be high in DRIVE and FINISH, and low in IDLE.
REQ-021 In FINISH, done SHALL pulse for exactly one cycle, and pass SHALL load (err_cnt==0), including a mismatch found on the final sample.
REQ-022 pass and err_cnt SHALL hold their values in IDLE until the next start.
REQ-023 start asserted while busy SHALL be ignored, with no restart and no queuing.
REQ-024 In IDLE, a_out and b_out SHALL return to 0 and vec_idx SHALL return to 0.
REQ-025 Total run latency from start to the done pulse SHALL be 4*HOLD+1 cycles.

Reset
REQ-026 While rst_n is low, all of the following SHALL apply immediately and asynchronously:
- FSM in IDLE.
- a_out, b_out, busy, done and pass = 0.
- vec_idx = 0, err_cnt = 0, hold counter = 0.
REQ-027 Reset asserted mid-sequence SHALL abort the run without a done pulse.
REQ-028 After rst_n deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-029 Macro GATE_VEC_SEQ_CHECK_EN SHALL control the result checker.
- Defined: the checker is compiled in, and REQ-018 and REQ-021 apply.
- Undefined: f_in is unused, err_cnt is tied to 0, and pass pulses high together with done; sequencing is unchanged.

Verification
REQ-030 Scenario: OP=0, HOLD=10, ideal AND gate attached, start at cycle 5 -> a/b follow 00,01,11,10 for 10 cycles each, done at cycle 46, err_cnt=0, pass=1.
REQ-031 Scenario: OP=0 with an OR gate attached -> mismatches at 01 and 10, err_cnt=2, pass=0.
REQ-032 Scenario: OP=3 with f_in stuck at 0 -> mismatches at 00 and 11, err_cnt=2; the next run with a correct XNOR gate clears to err_cnt=0, pass=1.
REQ-033 Scenario: start pulsed again during vector 2 -> sequence unaffected, a single done pulse.
REQ-034 Scenario: rst_n low during vector 1 -> all outputs 0 within the same cycle, no done pulse; a later start runs normally.
REQ-035 Scenario: built without GATE_VEC_SEQ_CHECK_EN and f_in toggling randomly -> err_cnt=0, pass=1 with done.
